prime_power_scheduler: RTL and testbench
========================================

# prime_power_scheduler

Sequences the prime stream produced by the sieve into the prime-power schedule that Pollard's p-1 stage 1 consumes. For a smoothness bound B it accepts primes in increasing order, computes for each prime p ≤ B the largest power p^k ≤ B by iterated multiplication, and hands each power to the modular-exponentiation unit over a valid/ready handshake. It sits between the sieve output and the exponentiation datapath and owns when primes are pulled and when the run ends.

## Interface
- PW, 9: prime width (sieve range 2..255).
- BW, 16: bound and prime-power width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- bound  in  BW  smoothness bound B; latched on accepted start.
- prime_valid  in  1  upstream prime available.
- prime  in  PW  current prime; strictly increasing across handshakes.
- prime_last  in  1  qualifies prime as the final table entry.
- prime_ready  out  1  scheduler accepts prime this cycle.
- pw_valid  out  1  prime power available.
- pw_data  out  BW  p^k, the largest power of p ≤ B.
- pw_ready  in  1  exponentiation unit accepts pw_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- count  out  8  powers emitted in the current or last run.

## Operation
- States: IDLE, FETCH, POWER, EMIT, DONE.
- IDLE: on start, latch B into b_r, clear count. If B < 2, go to DONE. Otherwise go to FETCH.
- FETCH: prime_ready=1. On prime_valid:
  - If prime > b_r, consume the prime and go to DONE.
  - Otherwise set p_r=prime, q_r=prime, last_r=prime_last, and go to POWER.
- POWER: form prod = q_r*p_r, 25 bits wide with no truncation.
  - If prod ≤ b_r, set q_r=prod[15:0] and stay in POWER.
  - Otherwise go to EMIT.
- EMIT: pw_valid=1, pw_data=q_r. On pw_ready, count+1; then go to DONE if last_r, else to FETCH.
- DONE: done=1 for exactly one cycle, then go to IDLE. count holds until the next accepted start.
- start is ignored when not in IDLE.
- A prime whose value exceeds B is consumed and terminates the run. Primes after it are never requested.
- Monotonicity of the prime stream is the upstream's responsibility and is not checked.
- Reset value of every output is 0. State resets to IDLE and b_r, p_r, q_r, last_r reset to 0.
- Reset asserted in any state, including mid-POWER or mid-EMIT, aborts the run on that edge. done does not pulse and no partial power is emitted.

## Timing
- All outputs are registered or decoded from state only. There are no combinational paths from input to output except through the state register.
- start accepted at edge n puts the block in FETCH at n+1. For B < 2 it is in DONE at n+1 instead.
- Prime accepted at edge m:
  - POWER occupies cycles m+1 .. m+k, where k is the final exponent.
  - EMIT begins at m+k+1.
- pw_data and pw_valid stay stable while pw_ready is low. The transfer completes on the first edge where both are high.
- Back-pressure from either side stalls without loss.
- Best-case throughput per prime is k+2 cycles (FETCH, k POWER cycles, EMIT).
- done asserts the cycle after the terminating handshake (prime > B accepted, or EMIT with last_r). busy falls in the same cycle done falls.

## Test plan
- **B=10, primes 2,3,5,7,11 (11 not last).** Expect pw_data 8, 9, 5, 7 in that order. Then 11 is consumed, done pulses once, and count=4. For prime 2: POWER for 3 cycles, pw_valid 4 cycles after the prime handshake.
- **B=1.** done pulses one cycle after start. prime_ready never asserts, pw_valid stays 0, and count=0.
- **B=255, full sieve table 2..251 with prime_last on 251.**
  - First powers: 128, 243, 125, 49, 121, 169.
  - Every prime ≥17 is emitted as itself.
  - Run ends via prime_last; count=54.
- **B=65535, single prime 251 marked last.** Expect pw_data=63001, a 25-bit prod of 15813251 with no overflow, then done.
- **Back-pressure.** With B=10, hold pw_ready low 5 cycles during the emission of 8, and prime_valid low 3 cycles in FETCH. pw_data must stay 8 throughout, with no duplicate or dropped powers. Final sequence is unchanged.
- **Reset and stray start.** Assert rst_n=0 during POWER of prime 3 → all outputs 0 next cycle with no done pulse. Pulse start mid-run → ignored, and b_r and count are unaffected.

Source files
------------

// File: rtl/prime_power_scheduler.sv
// rtl/prime_power_scheduler.sv - turns a sieve prime stream into the largest prime powers <= B for p-1 stage 1
module prime_power_scheduler #(
    parameter int PW = 9,
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [BW-1:0] bound,
    input  logic          prime_valid,
    input  logic [PW-1:0] prime,
    input  logic          prime_last,
    output logic          prime_ready,
    output logic          pw_valid,
    output logic [BW-1:0] pw_data,
    input  logic          pw_ready,
    output logic          busy,
    output logic          done,
    output logic [7:0]    count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        POWER = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [BW-1:0]    b_r;
    logic [BW-1:0]    q_r;
    logic [PW-1:0]    p_r;
    logic             last_r;

    logic [BW-1:0]    primeExt;
    logic [BW+PW-1:0] boundExt;
    logic [BW+PW-1:0] prod;

    // Full-width product so an overshoot past B is never hidden by wraparound
    assign primeExt = {{(BW-PW){1'b0}}, prime};
    assign boundExt = {{PW{1'b0}}, b_r};
    assign prod     = {{PW{1'b0}}, q_r} * {{BW{1'b0}}, p_r};

    // The current power is held in q_r, which doubles as the output data register
    assign pw_data  = q_r;

    // Scheduler FSM; every flag output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            b_r         <= '0;
            p_r         <= '0;
            q_r         <= '0;
            last_r      <= 1'b0;
            prime_ready <= 1'b0;
            pw_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_r   <= bound;
                        count <= '0;
                        busy  <= 1'b1;
                        if (bound < BW'(2)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            prime_ready <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (prime_valid) begin
                        prime_ready <= 1'b0;
                        if (primeExt > b_r) begin
                            // A prime beyond B ends the run; nothing further is pulled
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            p_r    <= prime;
                            q_r    <= primeExt;
                            last_r <= prime_last;
                            state  <= POWER;
                        end
                    end
                end
                POWER: begin
                    if (prod <= boundExt) begin
                        q_r <= prod[BW-1:0];
                    end else begin
                        state    <= EMIT;
                        pw_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (pw_ready) begin
                        pw_valid <= 1'b0;
                        count    <= count + 8'd1;
                        if (last_r) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            prime_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    prime_ready <= 1'b0;
                    pw_valid    <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_power_scheduler.sv
// tb/tb_prime_power_scheduler.sv - bench for prime_power_scheduler
module tb_prime_power_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bound;
    logic        prime_valid;
    logic [8:0]  prime;
    logic        prime_last;
    logic        prime_ready;
    logic        pw_valid;
    logic [15:0] pw_data;
    logic        pw_ready;
    logic        busy;
    logic        done;
    logic [7:0]  count;

    prime_power_scheduler #(.PW(9), .BW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bound(bound),
        .prime_valid(prime_valid), .prime(prime), .prime_last(prime_last),
        .prime_ready(prime_ready), .pw_valid(pw_valid), .pw_data(pw_data),
        .pw_ready(pw_ready), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int primeTbl[54] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61,
                         67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137,
                         139, 149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211,
                         223, 227, 229, 233, 239, 241, 251};

    typedef struct {
        int b;
        int sIdx;
        int n;
        bit lastOnEnd;
        int mode;
        int expCount;
        int expFirst;
        int expLast;
    } vec_t;

    vec_t tbl[7];
    int   gotQ[$];
    int   expQ[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: largest p^k <= B for each offered prime until one exceeds B or the last is taken
    task automatic model(input int b, input int sIdx, input int n, input bit lastOnEnd);
        longint pw;
        expQ.delete();
        if (b >= 2) begin
            for (int i = 0; i < n; i++) begin
                if (primeTbl[sIdx + i] > b) break;
                pw = primeTbl[sIdx + i];
                while (pw * primeTbl[sIdx + i] <= b) pw = pw * primeTbl[sIdx + i];
                expQ.push_back(int'(pw));
                if (lastOnEnd && i == n - 1) break;
            end
        end
    endtask

    // mode 0: no stalls, 1: random stalls, 2: scripted stalls plus a stray start
    task automatic doRun(input int b, input int sIdx, input int n, input bit lastOnEnd,
                         input int mode, input string tag);
        int idx, pvHold, rdyHold;
        bit prevStall, sawDone, pv, rdy;
        int prevData;
        gotQ.delete();
        @(negedge clk);
        start = 1'b1; bound = 16'(b); prime_valid = 1'b0; pw_ready = 1'b0; prime_last = 1'b0;
        @(negedge clk);
        start = 1'b0; bound = 16'($urandom);
        idx = 0; pvHold = 0; rdyHold = 0; prevStall = 0; sawDone = 0; prevData = 0;
        for (int cyc = 0; cyc < 3000 && !sawDone; cyc++) begin
            pv = (idx < n);
            if (mode == 1 && ($urandom % 4) == 0) pv = 1'b0;
            if (mode == 2 && prime_ready && idx == 1 && pvHold < 3) begin
                pv = 1'b0;
                pvHold++;
            end
            prime_valid = pv;
            prime       = (idx < n) ? 9'(primeTbl[sIdx + idx]) : 9'd0;
            prime_last  = lastOnEnd && (idx == n - 1);
            rdy = 1'b1;
            if (mode == 1 && ($urandom % 3) == 0) rdy = 1'b0;
            if (mode == 2 && pw_valid && gotQ.size() == 0 && rdyHold < 5) begin
                rdy = 1'b0;
                rdyHold++;
            end
            pw_ready = rdy;
            start = (mode == 2 && cyc == 6);
            if (start) bound = 16'd1;
            if (prevStall) begin
                check({tag, "_pw_valid_hold"}, pw_valid, 1);
                check({tag, "_pw_data_hold"}, pw_data, prevData);
            end
            prevStall = pw_valid && !pw_ready;
            prevData  = pw_data;
            if (prime_ready && prime_valid) idx++;
            if (pw_valid && pw_ready) gotQ.push_back(int'(pw_data));
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        start = 1'b0; prime_valid = 1'b0; pw_ready = 1'b0;
        check({tag, "_done_seen"}, sawDone, 1);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_after_done"}, busy, 0);
        model(b, sIdx, n, lastOnEnd);
        check({tag, "_count_vs_model"}, count, expQ.size());
        check({tag, "_len_vs_model"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            if (gotQ[i] != expQ[i]) check({tag, "_power"}, gotQ[i], expQ[i]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, b, sIdx;
        bit lastOnEnd;
        tbl[0] = '{10,    0,  5,  1'b0, 0, 4,  8,     7};
        tbl[1] = '{1,     0,  5,  1'b0, 0, 0,  0,     0};
        tbl[2] = '{255,   0,  54, 1'b1, 0, 54, 128,   251};
        tbl[3] = '{65535, 53, 1,  1'b1, 0, 1,  63001, 63001};
        tbl[4] = '{10,    0,  5,  1'b0, 2, 4,  8,     7};
        tbl[5] = '{2,     0,  2,  1'b0, 0, 1,  2,     2};
        tbl[6] = '{30,    0,  5,  1'b1, 1, 5,  16,    11};

        rst_n = 1'b0; start = 1'b0; bound = '0; prime_valid = 1'b0; prime = '0;
        prime_last = 1'b0; pw_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_prime_ready", prime_ready, 0);
        check("reset_pw_valid", pw_valid, 0);
        check("reset_pw_data", pw_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", count, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            doRun(tbl[t].b, tbl[t].sIdx, tbl[t].n, tbl[t].lastOnEnd, tbl[t].mode, $sformatf("vec%0d", t));
            check($sformatf("vec%0d_count", t), count, tbl[t].expCount);
            if (tbl[t].expCount > 0 && gotQ.size() > 0) begin
                check($sformatf("vec%0d_first", t), gotQ[0], tbl[t].expFirst);
                check($sformatf("vec%0d_last", t), gotQ[gotQ.size() - 1], tbl[t].expLast);
            end
        end

        // Latency for prime 2 with B=10: FETCH right after start, 3 POWER cycles, then EMIT
        @(negedge clk);
        start = 1'b1; bound = 16'd10;
        @(negedge clk);
        start = 1'b0;
        check("start_to_fetch_ready", prime_ready, 1);
        check("start_to_fetch_busy", busy, 1);
        prime_valid = 1'b1; prime = 9'd2; prime_last = 1'b1;
        @(negedge clk);
        prime_valid = 1'b0;
        n = 0;
        while (!pw_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("power_cycles_p2", n, 3);
        check("emit_data_p2", pw_data, 8);
        pw_ready = 1'b1;
        @(negedge clk);
        pw_ready = 1'b0;
        check("last_done_pulse", done, 1);
        check("last_count", count, 1);
        @(negedge clk);
        check("last_done_fall", done, 0);

        // B=1: done one cycle after start, no prime requested
        prime_valid = 1'b1; prime = 9'd2;
        start = 1'b1; bound = 16'd1;
        @(negedge clk);
        start = 1'b0;
        check("b1_done", done, 1);
        check("b1_prime_ready", prime_ready, 0);
        @(negedge clk);
        check("b1_done_fall", done, 0);
        check("b1_pw_valid", pw_valid, 0);
        check("b1_count", count, 0);
        prime_valid = 1'b0;

        // Reset during POWER of prime 3
        start = 1'b1; bound = 16'd10; prime_last = 1'b0;
        @(negedge clk);
        start = 1'b0;
        prime_valid = 1'b1; prime = 9'd2;
        n = 0;
        while (!prime_ready && n < 20) begin n++; @(negedge clk); end
        @(negedge clk);
        prime_valid = 1'b0;
        n = 0;
        while (!pw_valid && n < 20) begin n++; @(negedge clk); end
        check("rst_seq_emit8", pw_data, 8);
        pw_ready = 1'b1;
        @(negedge clk);
        pw_ready = 1'b0;
        prime_valid = 1'b1; prime = 9'd3;
        n = 0;
        while (!prime_ready && n < 20) begin n++; @(negedge clk); end
        @(negedge clk);
        prime_valid = 1'b0;
        check("rst_seq_in_power", {busy, prime_ready, pw_valid, done}, 4'b1000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_prime_ready", prime_ready, 0);
        check("rst_mid_pw_valid", pw_valid, 0);
        check("rst_mid_pw_data", pw_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_count", count, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
        end

        // Random runs against the reference model
        for (int r = 0; r < 30; r++) begin
            b = (($urandom % 3) == 0) ? int'($urandom % 65536) : int'($urandom % 300);
            sIdx = int'($urandom % 54);
            n = 1 + int'($urandom % (54 - sIdx));
            lastOnEnd = (primeTbl[sIdx + n - 1] <= b) ? 1'b1 : 1'($urandom % 2);
            doRun(b, sIdx, n, lastOnEnd, 1, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
